// File: rtl/temac_tx_arbiter.sv
// Two-port round-robin frame arbiter for the TEMAC client TX interface.
// Runs the first-byte/ack handshake, enforces the inter-frame gap and counts frames/underruns.
module temac_tx_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_125,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_dvld,
    input  logic             mac_tx_ack,
    output logic             mac_tx_underrun,
    input  logic             mac_syncacquired,
    output logic             grant,
    output logic             busy,
    output logic [CNT_W-1:0] frames0,
    output logic [CNT_W-1:0] frames1,
    output logic [CNT_W-1:0] underruns
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_STREAM,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_next;
    logic       grant_q;
    logic       last_grant;
    logic [7:0] gap_cnt;

    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       sel_ready;
    logic       start;
    logic       pick;
    logic       frame_done;
    logic       underrun_evt;

    assign sel_valid = grant_q ? req1_valid : req0_valid;
    assign sel_last  = grant_q ? req1_last  : req0_last;
    assign sel_data  = grant_q ? req1_data  : req0_data;

    // On contention the port that did not own the previous frame wins.
    assign start = mac_syncacquired && (req0_valid || req1_valid);
    assign pick  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        frame_done   = 1'b0;
        underrun_evt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (mac_tx_ack) begin
                    if (sel_last) begin
                        state_next = ST_GAP;
                        frame_done = 1'b1;
                    end else begin
                        state_next = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (!sel_valid) begin
                    state_next   = ST_DRAIN;
                    underrun_evt = 1'b1;
                end else if (sel_last) begin
                    state_next = ST_GAP;
                    frame_done = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (sel_valid && sel_last) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mac_tx_dvld = 1'b0;
        mac_tx_data = 8'h00;
        sel_ready   = 1'b0;
        busy        = 1'b0;
        unique case (state)
            ST_WAIT_ACK: begin
                mac_tx_dvld = 1'b1;
                mac_tx_data = sel_data;
                sel_ready   = mac_tx_ack;
                busy        = 1'b1;
            end
            ST_STREAM: begin
                mac_tx_dvld = sel_valid;
                mac_tx_data = sel_data;
                sel_ready   = sel_valid;
                busy        = 1'b1;
            end
            ST_DRAIN: begin
                sel_ready = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                mac_tx_dvld = 1'b0;
            end
        endcase
    end

    assign req0_ready = sel_ready & ~grant_q;
    assign req1_ready = sel_ready &  grant_q;
    assign grant      = grant_q;

    // The gap counter reaches zero on the cycle GAP hands back to IDLE.
    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            gap_cnt    <= 8'd0;
        end else begin
            if (state == ST_IDLE && start) begin
                grant_q    <= pick;
                last_grant <= pick;
            end
            if (state != ST_GAP && state_next == ST_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_125 or posedge reset) begin
        if (reset) begin
            mac_tx_underrun <= 1'b0;
            frames0         <= '0;
            frames1         <= '0;
            underruns       <= '0;
        end else begin
            mac_tx_underrun <= underrun_evt;
            if (frame_done) begin
                if (grant_q) begin
                    frames1 <= frames1 + CNT_ONE;
                end else begin
                    frames0 <= frames0 + CNT_ONE;
                end
            end
            if (underrun_evt) begin
                underruns <= underruns + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_temac_tx_arbiter.sv
// Scoreboard bench for temac_tx_arbiter: requester drivers, a TEMAC ack model,
// and a monitor that checks each frame seen on the MAC side against the queued frames.
`timescale 1ns/1ps
module tb_temac_tx_arbiter;

    localparam int GAP   = 4;
    localparam int CNT_W = 16;

    logic clk_125 = 1'b0;
    logic reset   = 1'b1;
    always #4 clk_125 = ~clk_125;

    logic             rv [2];
    logic             rl [2];
    logic [7:0]       rd [2];
    logic             req0_ready, req1_ready;
    logic [7:0]       mac_tx_data;
    logic             mac_tx_dvld;
    logic             mac_tx_ack = 1'b0;
    logic             mac_tx_underrun;
    logic             mac_syncacquired = 1'b1;
    logic             grant, busy;
    logic [CNT_W-1:0] frames0, frames1, underruns;
    logic             req0_valid, req1_valid, req0_last, req1_last;
    logic [7:0]       req0_data, req1_data;

    assign req0_valid = rv[0];
    assign req1_valid = rv[1];
    assign req0_last  = rl[0];
    assign req1_last  = rl[1];
    assign req0_data  = rd[0];
    assign req1_data  = rd[1];

    temac_tx_arbiter #(.GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
        .clk_125          (clk_125),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_data        (req0_data),
        .req0_last        (req0_last),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_data        (req1_data),
        .req1_last        (req1_last),
        .req1_ready       (req1_ready),
        .mac_tx_data      (mac_tx_data),
        .mac_tx_dvld      (mac_tx_dvld),
        .mac_tx_ack       (mac_tx_ack),
        .mac_tx_underrun  (mac_tx_underrun),
        .mac_syncacquired (mac_syncacquired),
        .grant            (grant),
        .busy             (busy),
        .frames0          (frames0),
        .frames1          (frames1),
        .underruns        (underruns)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Frame descriptor: id[31:16] len[15:8] underrun position[7:0] (0 = clean frame)
    function automatic int did(input int d);  return (d >> 16) & 16'hffff; endfunction
    function automatic int dlen(input int d); return (d >> 8) & 8'hff;     endfunction
    function automatic int dur(input int d);  return d & 8'hff;            endfunction

    function automatic logic [7:0] fbyte(input int id, input int i);
        int v;
        v = id * 37 + i * 11 + 5;
        return v[7:0];
    endfunction

    int dq0[$], dq1[$];
    int eq0[$], eq1[$];
    int next_id = 1;

    task automatic send(input int p, input int len, input int ur);
        int d;
        d = ((next_id & 16'hffff) << 16) | (len << 8) | ur;
        next_id++;
        if (p == 0) begin dq0.push_back(d); eq0.push_back(d); end
        else        begin dq1.push_back(d); eq1.push_back(d); end
    endtask

    // Requester drivers
    bit act [2];
    bit took [2];
    int idx [2];
    int cur [2];
    int hole [2];

    initial begin
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; rl[p] = 1'b0; rd[p] = 8'h00;
            act[p] = 1'b0; took[p] = 1'b0; idx[p] = 0; cur[p] = 0; hole[p] = 0;
        end
    end

    always @(negedge clk_125) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                act[p] = 1'b0; rv[p] = 1'b0; rl[p] = 1'b0; rd[p] = 8'h00;
            end else begin
                if (act[p] && took[p]) begin
                    idx[p]++;
                    if (idx[p] == dlen(cur[p])) act[p] = 1'b0;
                end
                if (!act[p]) begin
                    if (p == 0 && dq0.size() > 0) begin cur[p] = dq0.pop_front(); act[p] = 1'b1; end
                    else if (p == 1 && dq1.size() > 0) begin cur[p] = dq1.pop_front(); act[p] = 1'b1; end
                    if (act[p]) begin idx[p] = 0; hole[p] = 0; end
                end
                if (act[p]) begin
                    if (dur(cur[p]) != 0 && idx[p] == dur(cur[p]) && hole[p] < 3) begin
                        rv[p] = 1'b0; rl[p] = 1'b0;
                        hole[p]++;
                    end else begin
                        rv[p] = 1'b1;
                        rd[p] = fbyte(did(cur[p]), idx[p]);
                        rl[p] = (idx[p] == dlen(cur[p]) - 1);
                    end
                end else begin
                    rv[p] = 1'b0; rl[p] = 1'b0;
                end
            end
        end
        #3;
        took[0] = req0_valid && req0_ready;
        took[1] = req1_valid && req1_ready;
    end

    // TEMAC ack model: ack on the Nth cycle the first byte is presented
    int ack_fixed = 0;
    int wcnt = 0;
    int ack_n = 1;
    bit acked = 1'b0;

    always @(negedge clk_125) begin
        #1;
        mac_tx_ack = 1'b0;
        if (reset || !busy) begin
            acked = 1'b0; wcnt = 0;
        end else if (!acked) begin
            if (wcnt == 0) ack_n = (ack_fixed > 0) ? ack_fixed : int'($urandom_range(1, 4));
            wcnt++;
            if (wcnt == ack_n) begin mac_tx_ack = 1'b1; acked = 1'b1; end
        end
    end

    // Monitor and reference model
    logic [7:0] col[$];
    int  hist_grant[$], hist_low[$], hist_first[$], hist_dv[$], hist_busy[$];
    int  lg_m = 1;
    int  fr_m [2];
    int  ur_m = 0;
    int  ur_pulses = 0;
    int  dv_total = 0;
    int  low_run = 0;
    int  first_cyc = 0, dv_cyc = 0, busy_cyc = 0;
    bit  stray = 1'b0;
    bit  prev_busy = 1'b0, pv0 = 1'b0, pv1 = 1'b0, psync = 1'b0;

    task automatic finish_frame(input int g, input bit ur_seen);
        int d, len, ur, exp_n, bad;
        bit exp_ur, have;
        have = (g == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
        chk("sb_frame_expected", int'(have), 1);
        if (have) begin
            d = (g == 0) ? eq0.pop_front() : eq1.pop_front();
            len = dlen(d);
            ur = dur(d);
            exp_ur = (ur != 0);
            exp_n = exp_ur ? ur : len;
            chk("frame_underrun_flag", int'(ur_seen), int'(exp_ur));
            chk("frame_len", col.size(), exp_n);
            bad = -1;
            for (int i = 0; i < col.size() && i < exp_n; i++)
                if (bad < 0 && col[i] != fbyte(did(d), i)) bad = i;
            chk("frame_first_bad_byte", bad, -1);
            chk("ready_isolation", int'(stray), 0);
            if (exp_ur) ur_m++;
            else fr_m[g]++;
        end
        hist_first.push_back(first_cyc);
        hist_dv.push_back(dv_cyc);
        hist_busy.push_back(busy_cyc);
        col.delete();
        stray = 1'b0;
    endtask

    always @(negedge clk_125) begin
        int g, exp_g;
        bit rdy_g, rdy_o, last_g;
        #3;
        if (reset) begin
            lg_m = 1; fr_m[0] = 0; fr_m[1] = 0; ur_m = 0; ur_pulses = 0;
            col.delete(); stray = 1'b0; low_run = 0;
            prev_busy = 1'b0; pv0 = 1'b0; pv1 = 1'b0; psync = 1'b0;
        end else begin
            g = int'(grant);
            if (busy && !prev_busy) begin
                exp_g = (pv0 && pv1) ? (1 - lg_m) : (pv1 ? 1 : 0);
                chk("arb_request_present", int'(pv0 | pv1), 1);
                chk("arb_sync_gate", int'(psync), 1);
                chk("arb_grant", g, exp_g);
                lg_m = exp_g;
                hist_grant.push_back(g);
                hist_low.push_back(low_run);
                col.delete(); first_cyc = 0; dv_cyc = 0; busy_cyc = 0;
            end
            if (busy) busy_cyc++;
            rdy_g  = g ? req1_ready : req0_ready;
            rdy_o  = g ? req0_ready : req1_ready;
            last_g = g ? req1_last : req0_last;
            if (rdy_o || (!busy && (req0_ready || req1_ready))) stray = 1'b1;
            if (mac_tx_dvld) begin
                dv_cyc++; dv_total++; low_run = 0;
                if (col.size() == 0) first_cyc++;
            end else begin
                low_run++;
            end
            if (mac_tx_dvld && rdy_g) begin
                col.push_back(mac_tx_data);
                if (last_g) finish_frame(g, 1'b0);
            end
            if (mac_tx_underrun) begin
                ur_pulses++;
                chk("underrun_dvld_low", int'(mac_tx_dvld), 0);
                finish_frame(g, 1'b1);
            end
            prev_busy = busy; pv0 = req0_valid; pv1 = req1_valid; psync = mac_syncacquired;
        end
    end

    task automatic clear_hist();
        hist_grant.delete(); hist_low.delete(); hist_first.delete();
        hist_dv.delete(); hist_busy.delete();
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_frames0"}, int'(frames0), fr_m[0]);
        chk({tag, "_frames1"}, int'(frames1), fr_m[1]);
        chk({tag, "_underruns"}, int'(underruns), ur_m);
        chk({tag, "_underrun_pulses"}, ur_pulses, ur_m);
        chk({tag, "_frames_outstanding"}, eq0.size() + eq1.size(), 0);
    endtask

    task automatic wait_idle(input string tag);
        int q, n;
        q = 0; n = 0;
        while (q < GAP + 4 && n < 20000) begin
            @(negedge clk_125); #3;
            n++;
            if (!busy && !act[0] && !act[1] && dq0.size() == 0 && dq1.size() == 0) q++;
            else q = 0;
        end
        chk({tag, "_idle_reached"}, int'(n < 20000), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dq0.delete(); dq1.delete(); eq0.delete(); eq1.delete();
        repeat (3) @(negedge clk_125);
        reset = 1'b0;
        clear_hist();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, dv0, p, len, ur;

        // Reset state
        repeat (2) @(negedge clk_125);
        #3;
        chk("rst_dvld", int'(mac_tx_dvld), 0);
        chk("rst_data", int'(mac_tx_data), 0);
        chk("rst_underrun", int'(mac_tx_underrun), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_frames0", int'(frames0), 0);
        chk("rst_frames1", int'(frames1), 0);
        chk("rst_underruns", int'(underruns), 0);
        @(negedge clk_125);
        reset = 1'b0;

        // Single 64-byte frame, ack on the 5th cycle, followed by a second frame
        clear_hist();
        ack_fixed = 5;
        send(0, 64, 0);
        send(0, 64, 0);
        wait_idle("t1");
        chk("t1_frames_seen", hist_first.size(), 2);
        if (hist_first.size() >= 2) begin
            chk("t1_first_byte_cycles", hist_first[0], 5);
            chk("t1_dvld_cycles", hist_dv[0], 68);
            chk("t1_busy_cycles", hist_busy[0], 68);
            chk("t1_interframe_low", hist_low[1], GAP + 1);
        end
        chk("t1_frames0", int'(frames0), 2);
        check_counters("t1");

        // Contention: both ports continuously backlogged
        do_reset();
        ack_fixed = 0;
        send(0, 60, 0); send(1, 60, 0); send(0, 60, 0); send(1, 60, 0);
        wait_idle("t2");
        chk("t2_grants_seen", hist_grant.size(), 4);
        for (int i = 0; i < hist_grant.size() && i < 4; i++)
            chk("t2_grant_order", hist_grant[i], i % 2);
        chk("t2_frames0", int'(frames0), 2);
        chk("t2_frames1", int'(frames1), 2);
        check_counters("t2");

        // Sync gating
        do_reset();
        mac_syncacquired = 1'b0;
        dv0 = dv_total;
        send(1, 16, 0);
        repeat (20) @(negedge clk_125);
        chk("t3_dvld_held_low", dv_total - dv0, 0);
        mac_syncacquired = 1'b1;
        lat = 0;
        #3;
        while (!mac_tx_dvld && lat < 10) begin
            @(negedge clk_125); #3;
            lat++;
        end
        chk("t3_sync_latency", lat, 1);
        wait_idle("t3");
        check_counters("t3");

        // Underrun on port 1 at byte 20
        do_reset();
        send(1, 64, 20);
        wait_idle("t4");
        chk("t4_underruns", int'(underruns), 1);
        chk("t4_frames1", int'(frames1), 0);
        check_counters("t4");

        // One-byte frame, ack on the 2nd cycle
        do_reset();
        ack_fixed = 2;
        send(0, 1, 0);
        wait_idle("t5");
        chk("t5_frames_seen", hist_busy.size(), 1);
        if (hist_busy.size() >= 1) begin
            chk("t5_first_byte_cycles", hist_first[0], 2);
            chk("t5_busy_cycles", hist_busy[0], 2);
        end
        chk("t5_frames0", int'(frames0), 1);
        check_counters("t5");

        // Reset in the middle of a streaming frame
        do_reset();
        ack_fixed = 1;
        send(0, 8, 0);
        send(0, 64, 0);
        n = 0;
        @(negedge clk_125); #3;
        while (!(hist_grant.size() == 2 && col.size() >= 10) && n < 2000) begin
            @(negedge clk_125); #3;
            n++;
        end
        chk("t6_reached_byte10", int'(n < 2000), 1);
        chk("t6_pre_frames0", int'(frames0), 1);
        #2;
        reset = 1'b1;
        dq0.delete(); dq1.delete(); eq0.delete(); eq1.delete();
        #1;
        chk("t6_dvld_async", int'(mac_tx_dvld), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_frames0", int'(frames0), 0);
        chk("t6_underruns", int'(underruns), 0);
        repeat (3) @(negedge clk_125);
        reset = 1'b0;
        clear_hist();
        ack_fixed = 0;
        send(1, 10, 0);
        send(0, 10, 0);
        wait_idle("t6");
        chk("t6_post_frames_seen", hist_grant.size(), 2);
        if (hist_grant.size() >= 1) chk("t6_first_grant", hist_grant[0], 0);
        check_counters("t6");

        // Randomised traffic
        do_reset();
        ack_fixed = 0;
        for (int i = 0; i < 60; i++) begin
            p = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            ur = (len >= 3 && ($urandom % 8) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            send(p, len, ur);
            repeat ($urandom_range(0, 30)) @(negedge clk_125);
            if (($urandom % 6) == 0) begin
                mac_syncacquired = 1'b0;
                repeat ($urandom_range(1, 10)) @(negedge clk_125);
                mac_syncacquired = 1'b1;
            end
        end
        wait_idle("rand");
        check_counters("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
